// File: rtl/alu_op_sequencer.sv
// Opcode sequencer for the ALU: tracks ALT/FROM/TO prefixes, drives one EXEC cycle of
// ALU selects per ALU opcode, then writes z back and latches the status flags.
module alu_op_sequencer #(
    parameter int         DATA_W      = 16,
    parameter logic [3:0] DEFAULT_REG = 4'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        op_byte,
    input  logic              op_valid,
    output logic              op_ready,
    output logic [3:0]        x_reg_sel,
    output logic [3:0]        y_reg_sel,
    output logic [7:0]        instr,
    output logic              y_src_sel,
    output logic [2:0]        z_src_sel,
    output logic              add_sub_sel,
    input  logic [DATA_W-1:0] z,
    input  logic              cy,
    input  logic              ov,
    output logic              wr_en,
    output logic [3:0]        wr_reg,
    output logic              flag_z,
    output logic              flag_s,
    output logic              flag_cy,
    output logic              flag_ov
);

    typedef enum logic {FETCH, EXEC} state_t;

    state_t     state, state_nxt;
    logic [1:0] alt;
    logic [3:0] sreg, dreg;
    logic       arith_p1;
    logic       accept;
    logic [3:0] n;

    logic       dec_alu, dec_alt, dec_to, dec_from, dec_nop;
    logic       dec_imm, dec_sub, dec_wr, dec_arith;
    logic [2:0] dec_zsrc;

    assign n        = op_byte[3:0];
    assign op_ready = rst_n & (state == FETCH);
    assign accept   = op_valid & op_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    // Opcode decode and next-state
    always_comb begin
        dec_alu   = 1'b0;
        dec_alt   = 1'b0;
        dec_to    = 1'b0;
        dec_from  = 1'b0;
        dec_imm   = 1'b0;
        dec_sub   = 1'b0;
        dec_wr    = 1'b1;
        dec_arith = 1'b0;
        dec_zsrc  = 3'b000;
        case (op_byte[7:4])
            4'h1: dec_to   = 1'b1;
            4'hB: dec_from = 1'b1;
            4'h3: dec_alt  = (n >= 4'hD);
            4'h5: begin
                dec_alu   = 1'b1;
                dec_arith = 1'b1;
                dec_imm   = alt[1];
            end
            4'h6: begin
                dec_alu   = 1'b1;
                dec_arith = 1'b1;
                dec_sub   = 1'b1;
                dec_imm   = (alt == 2'd2);
                dec_wr    = (alt != 2'd3);
            end
            4'h7: begin
                dec_alu  = (n != 4'h0);
                dec_zsrc = 3'b001;
            end
            4'hC: begin
                // ALT1 and ALT3 both select XOR, so only alt[0] matters
                dec_alu  = (n != 4'h0);
                dec_zsrc = alt[0] ? 3'b011 : 3'b010;
            end
            4'h9: begin
                dec_alu  = (n == 4'h7);
                dec_zsrc = 3'b100;
            end
            4'h4: begin
                dec_alu  = (n == 4'hD);
                dec_zsrc = 3'b101;
            end
            default: ;
        endcase
        dec_nop = ~(dec_alu | dec_alt | dec_to | dec_from);

        state_nxt = state;
        case (state)
            FETCH: if (accept && dec_alu) state_nxt = EXEC;
            EXEC:  state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alt         <= 2'd0;
            sreg        <= DEFAULT_REG;
            dreg        <= DEFAULT_REG;
            x_reg_sel   <= 4'd0;
            y_reg_sel   <= 4'd0;
            instr       <= 8'd0;
            y_src_sel   <= 1'b0;
            z_src_sel   <= 3'b000;
            add_sub_sel <= 1'b0;
            wr_en       <= 1'b0;
            wr_reg      <= 4'd0;
            arith_p1    <= 1'b0;
            flag_z      <= 1'b0;
            flag_s      <= 1'b0;
            flag_cy     <= 1'b0;
            flag_ov     <= 1'b0;
        end else if (state == FETCH) begin
            // FETCH -> EXEC boundary: register the ALU controls for one full cycle
            if (accept) begin
                if (dec_alt)  alt  <= n[1:0];
                if (dec_to)   dreg <= n;
                if (dec_from) sreg <= n;
                if (dec_nop) begin
                    alt  <= 2'd0;
                    sreg <= DEFAULT_REG;
                    dreg <= DEFAULT_REG;
                end
                if (dec_alu) begin
                    x_reg_sel   <= sreg;
                    y_reg_sel   <= n;
                    wr_reg      <= dreg;
                    instr       <= dec_imm ? {4'h0, n} : 8'd0;
                    y_src_sel   <= dec_imm;
                    z_src_sel   <= dec_zsrc;
                    add_sub_sel <= dec_sub;
                    wr_en       <= dec_wr;
                    arith_p1    <= dec_arith;
                end
            end
        end else begin
            // EXEC -> FETCH boundary: capture flags, drop controls, restore default context
            flag_z <= (z == '0);
            flag_s <= z[DATA_W-1];
            if (arith_p1) begin
                flag_cy <= cy;
                flag_ov <= ov;
            end
            alt         <= 2'd0;
            sreg        <= DEFAULT_REG;
            dreg        <= DEFAULT_REG;
            x_reg_sel   <= 4'd0;
            y_reg_sel   <= 4'd0;
            instr       <= 8'd0;
            y_src_sel   <= 1'b0;
            z_src_sel   <= 3'b000;
            add_sub_sel <= 1'b0;
            wr_en       <= 1'b0;
            wr_reg      <= 4'd0;
            arith_p1    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: prefix tracking, EXEC controls, flag capture,
// handshake timing and asynchronous reset abort.
module tb_alu_op_sequencer;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        op_byte;
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        x_reg_sel, y_reg_sel, wr_reg;
    logic [7:0]        instr;
    logic              y_src_sel, add_sub_sel, wr_en;
    logic [2:0]        z_src_sel;
    logic [DATA_W-1:0] z;
    logic              cy, ov;
    logic              flag_z, flag_s, flag_cy, flag_ov;

    int n_chk  = 0;
    int n_fail = 0;

    alu_op_sequencer #(.DATA_W(DATA_W), .DEFAULT_REG(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .op_byte(op_byte), .op_valid(op_valid), .op_ready(op_ready),
        .x_reg_sel(x_reg_sel), .y_reg_sel(y_reg_sel), .instr(instr), .y_src_sel(y_src_sel),
        .z_src_sel(z_src_sel), .add_sub_sel(add_sub_sel), .z(z), .cy(cy), .ov(ov),
        .wr_en(wr_en), .wr_reg(wr_reg), .flag_z(flag_z), .flag_s(flag_s),
        .flag_cy(flag_cy), .flag_ov(flag_ov)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present a byte at a falling edge, hold it until accepted, return 1 ns after the accepting edge
    task automatic push(input logic [7:0] b);
        int k;
        @(negedge clk);
        op_byte  = b;
        op_valid = 1'b1;
        k = 0;
        while (!op_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!op_ready) chk("ready_timeout", {31'd0, op_ready}, 32'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic finish_exec(input logic [15:0] zv, input logic cyv, input logic ovv);
        z  = zv;
        cy = cyv;
        ov = ovv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        op_byte  = 8'h00;
        op_valid = 1'b0;
        z        = '0;
        cy       = 1'b0;
        ov       = 1'b0;
        #23;
        chk("rst_ready", {31'd0, op_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_flags", {28'd0, flag_z, flag_s, flag_cy, flag_ov}, 32'd0);
        chk("rst_ctrl", {17'd0, x_reg_sel, y_reg_sel, y_src_sel, z_src_sel, add_sub_sel}, 32'd0);
        chk("rst_instr", {24'd0, instr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, op_ready}, 32'd1);

        // Reset while ADD R3 is executing aborts it
        push(8'h53);
        chk("t1_exec_wr_en", {31'd0, wr_en}, 32'd1);
        chk("t1_exec_y", {28'd0, y_reg_sel}, 32'd3);
        z = 16'h0000; cy = 1'b1; ov = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_wr_en", {31'd0, wr_en}, 32'd0);
        chk("t1_async_ready", {31'd0, op_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1_fetch_ready", {31'd0, op_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("t1_flags", {28'd0, flag_z, flag_s, flag_cy, flag_ov}, 32'd0);

        // FROM R2, TO R5, ADD R3
        push(8'hB2);
        push(8'h15);
        chk("t2_prefix_wr_en", {31'd0, wr_en}, 32'd0);
        push(8'h53);
        chk("t2_x", {28'd0, x_reg_sel}, 32'd2);
        chk("t2_y", {28'd0, y_reg_sel}, 32'd3);
        chk("t2_wr_reg", {28'd0, wr_reg}, 32'd5);
        chk("t2_zsrc_addsub", {28'd0, z_src_sel, add_sub_sel}, 32'd0);
        chk("t2_wr_en", {31'd0, wr_en}, 32'd1);
        chk("t2_ready", {31'd0, op_ready}, 32'd0);
        finish_exec(16'h8000, 1'b0, 1'b1);
        chk("t2_flags_zscyov", {28'd0, flag_z, flag_s, flag_cy, flag_ov}, 32'b0101);
        chk("t2_wr_en_off", {31'd0, wr_en}, 32'd0);

        // ALT3 + 0x64 is CMP R4: no write, flags still updated
        push(8'h3F);
        push(8'h64);
        chk("t3_cmp_wr_en", {31'd0, wr_en}, 32'd0);
        chk("t3_cmp_sub", {31'd0, add_sub_sel}, 32'd1);
        chk("t3_cmp_x", {28'd0, x_reg_sel}, 32'd0);
        finish_exec(16'h0000, 1'b1, 1'b0);
        chk("t3_flags_zscyov", {28'd0, flag_z, flag_s, flag_cy, flag_ov}, 32'b1010);
        push(8'h64);
        chk("t3_alt_cleared_wr_en", {31'd0, wr_en}, 32'd1);
        chk("t3_sub_imm", {31'd0, y_src_sel}, 32'd0);
        finish_exec(16'h0001, 1'b1, 1'b1);
        chk("t3b_flags_zscyov", {28'd0, flag_z, flag_s, flag_cy, flag_ov}, 32'b0011);

        // ALT2 + 0x5F is ADD #15; a plain ADD follows with defaults restored
        push(8'h3E);
        push(8'h5F);
        chk("t4_imm_sel", {31'd0, y_src_sel}, 32'd1);
        chk("t4_instr", {24'd0, instr}, 32'h0F);
        chk("t4_addsub", {31'd0, add_sub_sel}, 32'd0);
        finish_exec(16'h1234, 1'b1, 1'b1);
        push(8'h51);
        chk("t4b_imm_sel", {31'd0, y_src_sel}, 32'd0);
        chk("t4b_instr", {24'd0, instr}, 32'h00);
        chk("t4b_x_wr", {24'd0, x_reg_sel, wr_reg}, 32'h00);
        chk("t4b_y", {28'd0, y_reg_sel}, 32'd1);
        finish_exec(16'h0002, 1'b1, 1'b1);

        // ALT1 + 0xC7 is XOR R7: CY/OV hold, Z/S follow z
        push(8'h3D);
        push(8'hC7);
        chk("t5_xor_zsrc", {29'd0, z_src_sel}, 32'b011);
        chk("t5_xor_y", {28'd0, y_reg_sel}, 32'd7);
        finish_exec(16'hFFFF, 1'b0, 1'b0);
        chk("t5_flags_zscyov", {28'd0, flag_z, flag_s, flag_cy, flag_ov}, 32'b0111);
        push(8'hC7);
        chk("t5_or_zsrc", {29'd0, z_src_sel}, 32'b010);
        finish_exec(16'h0000, 1'b0, 1'b0);
        chk("t5b_flags_zscyov", {28'd0, flag_z, flag_s, flag_cy, flag_ov}, 32'b1011);

        // op_valid held across ADD then SWAP: op_ready 1,0,1
        @(negedge clk);
        op_byte  = 8'h50;
        op_valid = 1'b1;
        chk("t6_ready0", {31'd0, op_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("t6_ready1", {31'd0, op_ready}, 32'd0);
        op_byte = 8'h4D;
        z = 16'h0000; cy = 1'b0; ov = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_ready2", {31'd0, op_ready}, 32'd1);
        chk("t6_add_flags", {28'd0, flag_z, flag_s, flag_cy, flag_ov}, 32'b1000);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        chk("t6_swap_ready", {31'd0, op_ready}, 32'd0);
        chk("t6_swap_zsrc", {29'd0, z_src_sel}, 32'b101);
        chk("t6_swap_wr_en", {31'd0, wr_en}, 32'd1);
        finish_exec(16'h8001, 1'b1, 1'b1);
        chk("t6_swap_flags", {28'd0, flag_z, flag_s, flag_cy, flag_ov}, 32'b0100);

        // Unknown byte between prefixes discards the earlier ones and leaves flags alone
        push(8'h3E);
        push(8'hB3);
        push(8'h00);
        chk("t6_nop_ready", {31'd0, op_ready}, 32'd1);
        chk("t6_nop_flags", {28'd0, flag_z, flag_s, flag_cy, flag_ov}, 32'b0100);
        push(8'h16);
        push(8'h5A);
        chk("t6_nop_x", {28'd0, x_reg_sel}, 32'd0);
        chk("t6_nop_imm", {31'd0, y_src_sel}, 32'd0);
        chk("t6_nop_wr_reg", {28'd0, wr_reg}, 32'd6);
        finish_exec(16'h0003, 1'b0, 1'b0);
        chk("t6_final_ctrl", {27'd0, wr_en, z_src_sel, y_src_sel}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
